// File: rtl/gaussian_3x3_filter.sv
// Streaming 3x3 Gaussian blur ([1 2 1; 2 4 2; 1 2 1] / 16) over a raster frame,
// "valid" convolution producing a (ROWS-2) x (COLS-2) output frame.
module gaussian_3x3_filter #(
    parameter int PIXEL_BIT_WIDTH = 16,
    parameter int ROWS            = 48,
    parameter int COLS            = 48
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in_TDATA,
    input  logic                       pixel_in_TVALID,
    output logic                       pixel_in_TREADY,
    output logic [PIXEL_BIT_WIDTH-1:0] pixel_out_TDATA,
    output logic                       pixel_out_TVALID,
    input  logic                       pixel_out_TREADY,
    output logic                       pixel_out_TLAST
);

    localparam int W  = PIXEL_BIT_WIDTH;
    localparam int SW = PIXEL_BIT_WIDTH + 4;
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

    // Handshake: a beat moves on a rising edge only when TVALID and TREADY are both high.
    // The single output register frees up whenever it is empty or being drained.
    logic in_accept;
    logic out_load;

    logic [RW-1:0] in_row_q, in_row_d;
    logic [CW-1:0] in_col_q, in_col_d;

    logic [W-1:0] out_data_q, out_data_d;
    logic         out_valid_q, out_valid_d;
    logic         out_last_q, out_last_d;

    logic signed [W-1:0] line0_q [COLS];
    logic signed [W-1:0] line1_q [COLS];
    logic signed [W-1:0] win_q [3][3];
    logic signed [W-1:0] win_d [3][3];
    logic signed [SW-1:0] sum;

    function automatic logic signed [SW-1:0] sx(input logic signed [W-1:0] p);
        return {{4{p[W-1]}}, p};
    endfunction

    assign pixel_in_TREADY = !out_valid_q || pixel_out_TREADY;
    assign in_accept       = pixel_in_TVALID && pixel_in_TREADY;
    // Columns 0/1 of a row would mix in the previous row's tail, so they never produce output.
    assign out_load        = in_accept && (in_row_q >= RW'(2)) && (in_col_q >= CW'(2));

    always_comb begin
        in_row_d = in_row_q;
        in_col_d = in_col_q;
        if (in_accept) begin
            if (in_col_q == LAST_COL) begin
                in_col_d = '0;
                in_row_d = (in_row_q == LAST_ROW) ? '0 : in_row_q + RW'(1);
            end else begin
                in_col_d = in_col_q + CW'(1);
            end
        end
    end

    // Window rows: 0 = two rows up, 2 = current row; column 2 is the newest.
    always_comb begin
        win_d = win_q;
        if (in_accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = line1_q[in_col_q];
            win_d[1][2] = line0_q[in_col_q];
            win_d[2][2] = pixel_in_TDATA;
        end
    end

    always_comb begin
        sum = sx(win_d[0][0]) + sx(win_d[0][2]) + sx(win_d[2][0]) + sx(win_d[2][2])
            + ((sx(win_d[0][1]) + sx(win_d[1][0]) + sx(win_d[1][2]) + sx(win_d[2][1])) <<< 1)
            + (sx(win_d[1][1]) <<< 2);
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if (out_load) begin
            out_data_d  = W'(sum >>> 4);
            out_valid_d = 1'b1;
            out_last_d  = (in_row_q == LAST_ROW) && (in_col_q == LAST_COL);
        end else if (out_valid_q && pixel_out_TREADY) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_row_q    <= '0;
            in_col_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            in_row_q    <= in_row_d;
            in_col_q    <= in_col_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // Line buffers and window hold only pixel history, so they carry no reset.
    always_ff @(posedge clk) begin
        win_q <= win_d;
        if (in_accept) begin
            line0_q[in_col_q] <= pixel_in_TDATA;
            line1_q[in_col_q] <= line0_q[in_col_q];
        end
    end

    assign pixel_out_TDATA  = out_data_q;
    assign pixel_out_TVALID = out_valid_q;
    assign pixel_out_TLAST  = out_last_q;

endmodule

// File: tb/tb_gaussian_3x3_filter.sv
// Bench for gaussian_3x3_filter: image-level reference model feeding an expected queue,
// random TVALID/TREADY throttling, and a monitor that pops and compares every output beat.
module tb_gaussian_3x3_filter;

    localparam int W     = 16;
    localparam int ROWS  = 48;
    localparam int COLS  = 48;
    localparam int OUT_N = (ROWS - 2) * (COLS - 2);

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] pixel_in_TDATA = '0;
    logic         pixel_in_TVALID = 1'b0;
    logic         pixel_in_TREADY;
    logic [W-1:0] pixel_out_TDATA;
    logic         pixel_out_TVALID;
    logic         pixel_out_TREADY = 1'b1;
    logic         pixel_out_TLAST;

    gaussian_3x3_filter #(.PIXEL_BIT_WIDTH(W), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk              (clk),
        .reset            (reset),
        .pixel_in_TDATA   (pixel_in_TDATA),
        .pixel_in_TVALID  (pixel_in_TVALID),
        .pixel_in_TREADY  (pixel_in_TREADY),
        .pixel_out_TDATA  (pixel_out_TDATA),
        .pixel_out_TVALID (pixel_out_TVALID),
        .pixel_out_TREADY (pixel_out_TREADY),
        .pixel_out_TLAST  (pixel_out_TLAST)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [W:0]   exp_q[$];
    int           ready_pct = 100;
    bit           ignore_out = 1'b0;
    int           out_count = 0;
    logic signed [W-1:0] img [ROWS][COLS];
    logic [W-1:0] first_exp;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fill(input int mode);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                case (mode)
                    0: img[r][c] = W'(r * COLS + c);
                    1: img[r][c] = 16'h7FFF;
                    2: img[r][c] = 16'h8000;
                    3: img[r][c] = (r == 10 && c == 10) ? 16'sd16 : 16'sd0;
                    default: img[r][c] = W'($urandom_range(0, 65535));
                endcase
    endtask

    // Reference: direct weighted sum over the 3x3 neighbourhood, floor division by 16.
    task automatic push_expected();
        bit first = 1'b1;
        for (int r = 1; r < ROWS - 1; r++)
            for (int c = 1; c < COLS - 1; c++) begin
                int s = 0;
                int q;
                logic [W-1:0] d;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        s += ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1) * int'(img[r+dr][c+dc]);
                q = s / 16;
                if (s < 0 && (s % 16) != 0) q = q - 1;
                d = q[W-1:0];
                if (first) first_exp = d;
                first = 1'b0;
                exp_q.push_back({(r == ROWS - 2 && c == COLS - 2), d});
            end
    endtask

    // Driver tasks
    task automatic send_beat(input logic [W-1:0] d, input int vpct);
        forever begin
            @(negedge clk);
            pixel_in_TVALID = ($urandom_range(1, 100) <= vpct);
            pixel_in_TDATA  = pixel_in_TVALID ? d : W'($urandom_range(0, 65535));
            #1;
            if (pixel_in_TVALID && pixel_in_TREADY) break;
        end
    endtask

    task automatic send_frame(input int vpct, input int nbeats, input bit chk_lat);
        int n = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                if (n >= nbeats) return;
                send_beat(img[r][c], vpct);
                n++;
                if (chk_lat && r == 2 && c == 2) begin
                    check("valid_before_first", {{W{1'b0}}, pixel_out_TVALID}, 0);
                    @(posedge clk);
                    #1;
                    check("first_valid_latency", {{W{1'b0}}, pixel_out_TVALID}, 1);
                    check("first_data", {1'b0, pixel_out_TDATA}, {1'b0, first_exp});
                end
            end
    endtask

    task automatic drain(input int expected_count);
        int waited = 0;
        @(negedge clk);
        pixel_in_TVALID = 1'b0;
        while (exp_q.size() != 0 && waited < 20000) begin
            @(negedge clk);
            waited++;
        end
        repeat (8) @(negedge clk);
        check("outstanding_expected", exp_q.size(), 0);
        check("output_count", out_count, expected_count);
        exp_q.delete();
        out_count = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        pixel_in_TVALID = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_out_valid", {{W{1'b0}}, pixel_out_TVALID}, 0);
        check("reset_out_last", {{W{1'b0}}, pixel_out_TLAST}, 0);
        check("reset_out_data", {1'b0, pixel_out_TDATA}, 0);
        check("reset_in_ready", {{W{1'b0}}, pixel_in_TREADY}, 1);
    endtask

    // Scoreboard monitor: pops on each output handshake, checks hold-stability on stalls.
    initial begin
        logic [W:0] e;
        logic [W:0] hold_val;
        bit         hold = 1'b0;
        forever begin
            @(negedge clk);
            pixel_out_TREADY = ignore_out ? 1'b1 : ($urandom_range(1, 100) <= ready_pct);
            #1;
            if (reset) begin
                hold = 1'b0;
                continue;
            end
            if (hold && !ignore_out) begin
                check("stall_valid", {{W{1'b0}}, pixel_out_TVALID}, 1);
                check("stall_data_last", {pixel_out_TLAST, pixel_out_TDATA}, hold_val);
            end
            if (pixel_out_TVALID && pixel_out_TREADY) begin
                hold = 1'b0;
                if (!ignore_out) begin
                    out_count++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: actual 0x%0h expected none", pixel_out_TDATA);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", {1'b0, pixel_out_TDATA}, {1'b0, e[W-1:0]});
                        check("out_last", {{W{1'b0}}, pixel_out_TLAST}, {{W{1'b0}}, e[W]});
                    end
                end
            end else if (pixel_out_TVALID) begin
                hold = 1'b1;
                hold_val = {pixel_out_TLAST, pixel_out_TDATA};
            end else begin
                hold = 1'b0;
            end
        end
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: actual timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        apply_reset();

        // Index image at full rate, with first-output latency check
        ready_pct = 100;
        fill(0); push_expected(); send_frame(100, ROWS * COLS, 1); drain(OUT_N);

        // Extreme constants
        fill(1); push_expected(); send_frame(100, ROWS * COLS, 0); drain(OUT_N);
        fill(2); push_expected(); send_frame(100, ROWS * COLS, 0); drain(OUT_N);

        // Index image with 50% valid and ready
        ready_pct = 50;
        fill(0); push_expected(); send_frame(50, ROWS * COLS, 0); drain(OUT_N);

        // Single impulse
        ready_pct = 100;
        fill(3); push_expected(); send_frame(100, ROWS * COLS, 0); drain(OUT_N);

        // Random signed image with random throttling
        ready_pct = 70;
        fill(4); push_expected(); send_frame(70, ROWS * COLS, 0); drain(OUT_N);

        // Abort mid-frame after 1000 beats, then a clean frame
        ready_pct = 100;
        ignore_out = 1'b1;
        fill(0); send_frame(100, 1000, 0);
        apply_reset();
        ignore_out = 1'b0;
        push_expected(); send_frame(100, ROWS * COLS, 0); drain(OUT_N);

        // Two back-to-back frames, no gap
        fill(0); push_expected(); push_expected();
        send_frame(100, ROWS * COLS, 0); send_frame(100, ROWS * COLS, 0);
        drain(2 * OUT_N);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
